mips_mem_port: RTL and testbench
================================

MIPS_MEM_PORT -- requirements
Module: mips_mem_port

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 64, number of words; SHALL be a power of two.
REQ-004 Parameter WAIT_CYCLES, default 1, extra wait states per access; legal range 0..15.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  port can accept a request.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte-lane write enables.
REQ-013 rsp_valid  out  1  response present.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-016 rsp_err  out  1  access rejected (misaligned or out of range).

Function
REQ-017 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept = req_valid & req_ready at a rising edge. On accept, latch we/addr/wdata/be; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-019 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle; move to RESP when it reaches 0.
REQ-020 Request accepted at edge T SHALL first show rsp_valid=1 in the cycle after edge T+WAIT_CYCLES.
REQ-021 In RESP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_valid & rsp_ready at an edge, then go to IDLE.
REQ-022 No request is accepted in the same cycle a response completes; next accept earliest one cycle later.
REQ-023 Misaligned: addr low log2(DATA_W/8) bits nonzero. Out of range: any addr bit above the word-index field nonzero.
REQ-024 Either error SHALL set rsp_err=1, rsp_rdata=0, and leave memory unmodified.
REQ-025 Valid write SHALL update only lanes with req_be=1 on the edge entering RESP; rsp_rdata=0.
REQ-026 Valid read SHALL capture the word on the edge entering RESP, reflecting all earlier completed writes.
REQ-027 req_be=0 write SHALL complete normally with no memory change; req_be ignored on reads.
REQ-028 Inputs other than rsp_ready SHALL be ignored outside IDLE.

Reset
REQ-029 Reset SHALL override all activity, including mid-WAIT or mid-RESP; the pending access is discarded and any not-yet-committed write SHALL NOT occur.
REQ-030 After reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter 0.
REQ-031 Reset SHALL clear every memory word to 0.

Structure
REQ-032 Package mips_mem_pkg SHALL hold the FSM state enum and derived width helpers (lane count, index width).
REQ-033 Storage SHALL be a sub-module mips_mem_array (byte-lane write, synchronous read, synchronous clear); mips_mem_port holds FSM, counter, address checks.

Verification (DATA_W=32, DEPTH=64, WAIT_CYCLES=2 unless stated)
REQ-034 Reset, write 0xDEADBEEF to 0x10 with be=0xF, read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 3 cycles after each accept.
REQ-035 Write 0x11223344 to 0x20 be=0xF, then 0xAABBCCDD be=0x5, read 0x20 -> 0x11BB33DD.
REQ-036 Read 0x22 and read 0x100 -> rsp_err=1, rsp_rdata=0; read of 0x20 afterward unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; accept completes on rsp_ready=1.
REQ-038 Assert reset during WAIT of a write of 0x55 to 0x04 -> outputs at reset values, read 0x04 returns 0.
REQ-039 WAIT_CYCLES=0, back-to-back reads with rsp_ready=1 -> one response every 2 cycles, rsp_valid one cycle after accept.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module : mips_mem_pkg
// Brief  : Shared FSM state type and width helpers for the MIPS memory port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int c_cnt_w = 4;

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(input int depth);
        return $clog2(depth);
    endfunction

    // Vector width for the word index; never zero even for a single-word memory.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_mem_array.sv
// ============================================================================
// Module : mips_mem_array
// Brief  : Word storage with byte-lane writes, registered read, sync clear.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_we,
    input  logic                          i_re,
    input  logic [idx_width(DEPTH)-1:0]   i_idx,
    input  logic [lane_cnt(DATA_W)-1:0]   i_be,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]             o_rdata
);

    localparam int c_lanes = lane_cnt(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                for (int b = 0; b < c_lanes; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
                    end
                end
            end
            if (i_re) begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mips_mem_port.sv
// ============================================================================
// Module : mips_mem_port
// Brief  : Valid/ready memory port with wait states and address checking.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_mem_port
    import mips_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [DATA_W/8-1:0]  req_be,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err
);

    localparam int c_lanes    = lane_cnt(DATA_W);
    localparam int c_off_bits = off_bits(DATA_W);
    localparam int c_idx_bits = idx_bits(DEPTH);
    localparam int c_idx_w    = idx_width(DEPTH);
    localparam int c_top      = c_off_bits + c_idx_bits;
    localparam logic [c_cnt_w-1:0] c_wait_load =
        (WAIT_CYCLES > 0) ? c_cnt_w'(WAIT_CYCLES - 1) : '0;

    state_t               r_state;
    state_t               w_next;
    logic                 w_enter_resp;
    logic                 w_accept;

    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [c_lanes-1:0]   r_be;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_err;
    logic                 r_rd_ok;

    logic                 w_we;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [c_lanes-1:0]   w_be;
    logic                 w_misaligned;
    logic                 w_oor;
    logic                 w_err;
    logic [c_idx_w-1:0]   w_idx;
    logic [DATA_W-1:0]    w_arr_rdata;

    assign w_accept = req_valid && (r_state == ST_IDLE);

    // With zero wait states the access commits on the accept edge itself, so
    // the array must see the live request; otherwise it sees the latched one.
    assign w_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_be    = (r_state == ST_IDLE) ? req_be    : r_be;

    assign w_misaligned = |(w_addr & ADDR_W'(c_lanes - 1));
    assign w_oor        = |(w_addr >> c_top);
    assign w_err        = w_misaligned | w_oor;
    assign w_idx        = c_idx_w'(w_addr >> c_off_bits);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next       = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    w_enter_resp = (WAIT_CYCLES == 0);
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next       = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= c_wait_load;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rd_ok <= ~w_we & ~w_err;
            end
        end
    end

    mips_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .i_we    (w_enter_resp & w_we & ~w_err),
        .i_re    (w_enter_resp & ~w_we & ~w_err),
        .i_idx   (w_idx),
        .i_be    (w_be),
        .i_wdata (w_wdata),
        .o_rdata (w_arr_rdata)
    );

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid & r_err;
    assign rsp_rdata = (rsp_valid && r_rd_ok) ? w_arr_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mips_mem_port.sv
// ============================================================================
// Module : tb_mips_mem_port
// Brief  : Randomized self-checking bench against a word-array reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_port;

    localparam int DEP = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        req_valid_z, req_ready_z, req_we_z, rsp_valid_z, rsp_ready_z, rsp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, rsp_rdata_z;
    logic [3:0]  req_be_z;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model   [DEP];
    logic [31:0] model_z [DEP];

    mips_mem_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mips_mem_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_we(req_we_z),
        .req_addr(req_addr_z), .req_wdata(req_wdata_z), .req_be(req_be_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
        .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z)
    );

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return $urandom | 32'h100;
        if (sel == 1) return ($urandom_range(0, 63) * 4) + $urandom_range(1, 3);
        return $urandom_range(0, 63) * 4;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_valid_z = 1'b0; rsp_ready_z = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            model[i] = '0;
            model_z[i] = '0;
        end
    endtask

    // One complete transaction on the wait-state port; results returned for checking.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rd, output logic err, output int lat,
                        output bit stable, output bit to);
        int guard;
        guard = 0; to = 0; stable = 1; lat = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) to = 1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
        @(negedge clk);
        while (rsp_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) to = 1;
        rd = rsp_rdata;
        err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== err || req_ready !== 1'b0)
                stable = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        checks++;
        if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs_z got ready=%b valid=%b exp 1 0", req_ready_z, rsp_valid_z);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic err; int lat; bit st, to;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, err, lat, st, to);
        model[4] = merge(model[4], 32'hDEADBEEF, 4'hF);
        checks++;
        if (to || lat != 2 || err !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL basic_write got lat=%0d err=%b rdata=%h to=%0d exp lat=2 err=0 rdata=0",
                     lat, err, rd, to);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (to || lat != 2 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_read got lat=%0d err=%b rdata=%h exp lat=2 err=0 rdata=deadbeef",
                     lat, err, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic err; int lat; bit st, to;
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, err, lat, st, to);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, rd, err, lat, st, to);
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (to || err !== 1'b0 || rd !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL lanes_read got rdata=%h err=%b exp 11bb33dd 0", rd, err);
        end
        xact(1'b1, 32'h20, 32'h99999999, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (to || err !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL be0_write_rsp got rdata=%h err=%b exp 0 0", rd, err);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            failures++;
            $display("FAIL be0_no_change got rdata=%h exp 11bb33dd", rd);
        end
        model[8] = 32'h11BB33DD;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int lat; bit st, to;
        xact(1'b0, 32'h22, 32'h0, 4'hF, 0, rd, err, lat, st, to);
        checks++;
        if (to || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_misaligned got err=%b rdata=%h exp 1 0", err, rd);
        end
        xact(1'b0, 32'h100, 32'h0, 4'hF, 0, rd, err, lat, st, to);
        checks++;
        if (to || err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_range got err=%b rdata=%h exp 1 0", err, rd);
        end
        xact(1'b1, 32'h120, 32'hCAFEF00D, 4'hF, 0, rd, err, lat, st, to);
        checks++;
        if (err !== 1'b1 || rd !== 32'h0) begin
            failures++;
            $display("FAIL err_range_write got err=%b rdata=%h exp 1 0", err, rd);
        end
        xact(1'b1, 32'h21, 32'hCAFEF00D, 4'hF, 0, rd, err, lat, st, to);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_misaligned_write got err=%b exp 1", err);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (err !== 1'b0 || rd !== model[8]) begin
            failures++;
            $display("FAIL err_no_change got rdata=%h err=%b exp %h 0", rd, err, model[8]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic err; int lat; bit st, to;
        xact(1'b0, 32'h20, 32'h0, 4'h0, 5, rd, err, lat, st, to);
        checks++;
        if (to || !st || rd !== model[8]) begin
            failures++;
            $display("FAIL backpressure got stable=%0d rdata=%h exp stable=1 rdata=%h", st, rd, model[8]);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, wd, exp_rd; logic err, we; logic [3:0] be; int lat; bit st, to, bad;
        for (int n = 0; n < 40; n++) begin
            a = rand_addr(); we = 1'($urandom); wd = $urandom; be = 4'($urandom);
            bad = addr_bad(a);
            exp_rd = (we || bad) ? 32'h0 : model[a / 4];
            xact(we, a, wd, be, $urandom_range(0, 2), rd, err, lat, st, to);
            if (we && !bad) model[a / 4] = merge(model[a / 4], wd, be);
            checks++;
            if (to || lat != 2 || err !== bad || rd !== exp_rd || !st) begin
                failures++;
                $display("FAIL random n=%0d we=%b addr=%h got rdata=%h err=%b lat=%0d exp rdata=%h err=%0d lat=2",
                         n, we, a, rd, err, lat, exp_rd, bad);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic err; int lat; bit st, to, seen;
        xact(1'b1, 32'h04, 32'h12345678, 4'hF, 0, rd, err, lat, st, to);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h04; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < DEP; i++) begin
            model[i] = '0;
            model_z[i] = '0;
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            failures++;
            $display("FAIL midwait_reset_outputs got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL midwait_discard got rsp_valid=1 exp 0");
        end
        xact(1'b0, 32'h04, 32'h0, 4'h0, 0, rd, err, lat, st, to);
        checks++;
        if (to || err !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL midwait_read got rdata=%h err=%b exp 0 0", rd, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, wd, exp_rd; logic we; logic [3:0] be; bit bad;
        exp_rd = '0; bad = 0;
        rsp_ready_z = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0) begin
                checks++;
                if (req_ready_z !== 1'b1 || rsp_valid_z !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle i=%0d got ready=%b valid=%b exp 1 0", i, req_ready_z, rsp_valid_z);
                end
                a = rand_addr(); we = (i < 40) ? 1'($urandom) : 1'b0;
                wd = $urandom; be = 4'($urandom);
                bad = addr_bad(a);
                exp_rd = (we || bad) ? 32'h0 : model_z[a / 4];
                if (we && !bad) model_z[a / 4] = merge(model_z[a / 4], wd, be);
                req_valid_z = 1'b1; req_we_z = we; req_addr_z = a; req_wdata_z = wd; req_be_z = be;
            end else begin
                checks++;
                if (rsp_valid_z !== 1'b1 || req_ready_z !== 1'b0 || rsp_rdata_z !== exp_rd || rsp_err_z !== bad) begin
                    failures++;
                    $display("FAIL b2b_resp i=%0d got valid=%b ready=%b rdata=%h err=%b exp 1 0 %h %0d",
                             i, rsp_valid_z, req_ready_z, rsp_rdata_z, rsp_err_z, exp_rd, bad);
                end
            end
            @(negedge clk);
        end
        req_valid_z = 1'b0;
        rsp_ready_z = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
        req_valid_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
        rsp_ready_z = 1'b0;
        do_reset();
        test_reset();
        test_basic();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
